// File: rtl/conv_mem_host_if.sv
// conv_mem_host_if: host/CONV bus between the system and the CONV host memory block
interface conv_mem_host_if #(
    parameter int DW     = 20,
    parameter int IMG_AW = 12
);
    logic              start;
    logic              img_we;
    logic [IMG_AW-1:0] img_waddr;
    logic [DW-1:0]     img_wdata;
    logic              ready;
    logic              busy;
    logic [11:0]       iaddr;
    logic [DW-1:0]     idata;
    logic              cwr;
    logic [11:0]       caddr_wr;
    logic [DW-1:0]     cdata_wr;
    logic              crd;
    logic [11:0]       caddr_rd;
    logic [DW-1:0]     cdata_rd;
    logic [2:0]        csel;
    logic              done;
    logic [31:0]       checksum;
    logic [15:0]       wr_cnt;
    logic              err_sel;

    modport master (
        output start, img_we, img_waddr, img_wdata, busy, iaddr,
               cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        input  ready, idata, cdata_rd, done, checksum, wr_cnt, err_sel
    );

    modport slave (
        input  start, img_we, img_waddr, img_wdata, busy, iaddr,
               cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        output ready, idata, cdata_rd, done, checksum, wr_cnt, err_sel
    );
endinterface

// File: rtl/conv_mem_host.sv
// conv_mem_host: image/layer memories, start handshake and post-run layer checksum for CONV
module conv_mem_host #(
    parameter int DW     = 20,
    parameter int IMG_AW = 12,
    parameter int L0_AW  = 12,
    parameter int L1_AW  = 10,
    parameter int L2_AW  = 11
) (
    input logic            clk,
    input logic            reset,
    conv_mem_host_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, RUN, SCAN, DONE} state_t;

    localparam int N0       = 1 << L0_AW;
    localparam int N1       = 1 << L1_AW;
    localparam int N2       = 1 << L2_AW;
    localparam int B1       = N0;
    localparam int B2       = 2 * N0;
    localparam int B3       = 2 * N0 + N1;
    localparam int B4       = 2 * N0 + 2 * N1;
    localparam int SCAN_LEN = B4 + N2;
    localparam int SW       = $clog2(SCAN_LEN);

    state_t          r_state;
    logic            r_ready;
    logic            r_done;
    logic            r_err_sel;
    logic [31:0]     r_checksum;
    logic [15:0]     r_wr_cnt;
    logic [SW-1:0]   r_scan_idx;

    logic [DW-1:0]   r_img  [1 << IMG_AW];
    logic [DW-1:0]   r_l0k0 [N0];
    logic [DW-1:0]   r_l0k1 [N0];
    logic [DW-1:0]   r_l1k0 [N1];
    logic [DW-1:0]   r_l1k1 [N1];
    logic [DW-1:0]   r_l2   [N2];

    logic             w_host_phase;
    logic             w_scan;
    logic             w_legal;
    logic             w_start_acc;
    logic             w_img_wr;
    logic             w_wr;
    logic             w_bad;
    logic [DW-1:0]    w_rd_word;
    logic [DW-1:0]    w_scan_word;
    logic [L0_AW-1:0] w_o0;
    logic [L0_AW-1:0] w_o1;
    logic [L1_AW-1:0] w_o2;
    logic [L1_AW-1:0] w_o3;
    logic [L2_AW-1:0] w_o4;

    assign w_host_phase = (r_state == IDLE) || (r_state == DONE);
    assign w_scan       = (r_state == SCAN);
    assign w_legal      = (bus.csel != 3'd0) && (bus.csel < 3'd6);
    assign w_start_acc  = bus.start && w_host_phase;
    assign w_img_wr     = bus.img_we && w_host_phase;
    assign w_wr         = bus.cwr && w_legal && !w_scan;
    assign w_bad        = (bus.cwr || bus.crd) && !w_legal && !w_scan;

    // Offsets of the scan index inside each bank's slice of the linear scan order
    assign w_o0 = L0_AW'(r_scan_idx);
    assign w_o1 = L0_AW'(r_scan_idx - SW'(B1));
    assign w_o2 = L1_AW'(r_scan_idx - SW'(B2));
    assign w_o3 = L1_AW'(r_scan_idx - SW'(B3));
    assign w_o4 = L2_AW'(r_scan_idx - SW'(B4));

    // Internal scan read port and CONV-facing layer read mux
    always_comb begin
        w_scan_word = (r_scan_idx < SW'(B1)) ? r_l0k0[w_o0] :
                      (r_scan_idx < SW'(B2)) ? r_l0k1[w_o1] :
                      (r_scan_idx < SW'(B3)) ? r_l1k0[w_o2] :
                      (r_scan_idx < SW'(B4)) ? r_l1k1[w_o3] : r_l2[w_o4];
        w_rd_word   = (bus.csel == 3'd1) ? r_l0k0[bus.caddr_rd[L0_AW-1:0]] :
                      (bus.csel == 3'd2) ? r_l0k1[bus.caddr_rd[L0_AW-1:0]] :
                      (bus.csel == 3'd3) ? r_l1k0[bus.caddr_rd[L1_AW-1:0]] :
                      (bus.csel == 3'd4) ? r_l1k1[bus.caddr_rd[L1_AW-1:0]] :
                                           r_l2[bus.caddr_rd[L2_AW-1:0]];
    end

    assign bus.idata    = r_img[bus.iaddr[IMG_AW-1:0]];
    assign bus.cdata_rd = (bus.crd && w_legal && !w_scan) ? w_rd_word : '0;
    assign bus.ready    = r_ready;
    assign bus.done     = r_done;
    assign bus.checksum = r_checksum;
    assign bus.wr_cnt   = r_wr_cnt;
    assign bus.err_sel  = r_err_sel;

    // Memory writes; contents survive reset and are never cleared
    always_ff @(posedge clk) begin
        if (w_img_wr) r_img[bus.img_waddr] <= bus.img_wdata;
        if (w_wr && bus.csel == 3'd1) r_l0k0[bus.caddr_wr[L0_AW-1:0]] <= bus.cdata_wr;
        if (w_wr && bus.csel == 3'd2) r_l0k1[bus.caddr_wr[L0_AW-1:0]] <= bus.cdata_wr;
        if (w_wr && bus.csel == 3'd3) r_l1k0[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
        if (w_wr && bus.csel == 3'd4) r_l1k1[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
        if (w_wr && bus.csel == 3'd5) r_l2[bus.caddr_wr[L2_AW-1:0]] <= bus.cdata_wr;
    end

    // Run-control FSM with registered handshake, status counters and scan accumulator;
    // events on the same edge as an accepted start count toward the new run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_err_sel  <= 1'b0;
            r_checksum <= '0;
            r_wr_cnt   <= '0;
            r_scan_idx <= '0;
        end else if (w_start_acc) begin
            r_state    <= ARM;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err_sel  <= w_bad;
            r_checksum <= '0;
            r_wr_cnt   <= {15'd0, w_wr};
        end else begin
            if (w_wr && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_bad) r_err_sel <= 1'b1;
            case (r_state)
                ARM: if (bus.busy) begin
                    r_state <= RUN;
                    r_ready <= 1'b0;
                end
                RUN: if (!bus.busy) begin
                    r_state    <= SCAN;
                    r_scan_idx <= '0;
                end
                SCAN: begin
                    r_checksum <= r_checksum + 32'(w_scan_word);
                    r_scan_idx <= r_scan_idx + 1'b1;
                    if (r_scan_idx == SW'(SCAN_LEN - 1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mem_host.sv
// tb_conv_mem_host: directed vector table plus hand sequences for handshake, scan and reset
module tb_conv_mem_host;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc;

    always #5 clk = ~clk;

    conv_mem_host_if bus();
    conv_mem_host dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        cwr;
        logic        crd;
        logic [2:0]  csel;
        logic [11:0] addr;
        logic [19:0] data;
        logic [19:0] exp_rd;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t tbl[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!bus.done && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic fill_ones();
        for (int s = 1; s <= 5; s++) begin
            int sz;
            sz = (s < 3) ? 4096 : (s < 5) ? 1024 : 2048;
            for (int a = 0; a < sz; a++) begin
                bus.cwr      = 1'b1;
                bus.csel     = 3'(s);
                bus.caddr_wr = 12'(a);
                bus.cdata_wr = 20'd1;
                step();
            end
        end
        bus.cwr = 1'b0;
    endtask

    initial begin
        //            cwr   crd   csel  addr     data       exp_rd     cnt    err
        tbl[0]  = '{1'b1, 1'b0, 3'd3, 12'hC05, 20'h0ABCD, 20'h00000, 16'd1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd3, 12'h005, 20'h00000, 20'h0ABCD, 16'd1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 3'd3, 12'h005, 20'h00000, 20'h00000, 16'd1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd1, 12'h123, 20'h11111, 20'h00000, 16'd2, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 3'd1, 12'h123, 20'h22222, 20'h11111, 16'd3, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'd1, 12'h123, 20'h00000, 20'h22222, 16'd3, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd2, 12'h123, 20'h33333, 20'h00000, 16'd4, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'd1, 12'h123, 20'h00000, 20'h22222, 16'd4, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'd4, 12'h3FF, 20'h44444, 20'h00000, 16'd5, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 3'd4, 12'hFFF, 20'h00000, 20'h44444, 16'd5, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd5, 12'h7FE, 20'h55555, 20'h00000, 16'd6, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'd5, 12'hFFE, 20'h00000, 20'h55555, 16'd6, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 3'd6, 12'h005, 20'hFFFFF, 20'h00000, 16'd6, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 3'd3, 12'h005, 20'h00000, 20'h0ABCD, 16'd6, 1'b1};

        bus.start = 1'b0; bus.img_we = 1'b0; bus.img_waddr = '0; bus.img_wdata = '0;
        bus.busy = 1'b0; bus.iaddr = '0; bus.cwr = 1'b0; bus.caddr_wr = '0;
        bus.cdata_wr = '0; bus.crd = 1'b0; bus.caddr_rd = '0; bus.csel = '0;

        repeat (3) step();
        check("rst ready", 32'(bus.ready), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst checksum", bus.checksum, 32'd0);
        check("rst wr_cnt", 32'(bus.wr_cnt), 32'd0);
        check("rst err_sel", 32'(bus.err_sel), 32'd0);
        check("rst cdata_rd", 32'(bus.cdata_rd), 32'd0);
        reset = 1'b1;
        step();

        bus.img_we = 1'b1; bus.img_waddr = 12'h041; bus.img_wdata = 20'h12345;
        step();
        bus.img_we = 1'b0; bus.iaddr = 12'h041;
        #1 check("idata idle load", 32'(bus.idata), 32'h12345);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ready after start", 32'(bus.ready), 32'd1);
        repeat (10) step();
        check("ready held busy=0", 32'(bus.ready), 32'd1);
        bus.busy = 1'b1;
        step();
        check("ready drop on busy", 32'(bus.ready), 32'd0);

        bus.img_we = 1'b1; bus.img_waddr = 12'h041; bus.img_wdata = 20'h54321;
        step();
        bus.img_we = 1'b0;
        check("idata run write dropped", 32'(bus.idata), 32'h12345);

        for (int i = 0; i < 14; i++) begin
            bus.cwr = tbl[i].cwr; bus.crd = tbl[i].crd; bus.csel = tbl[i].csel;
            bus.caddr_wr = tbl[i].addr; bus.caddr_rd = tbl[i].addr; bus.cdata_wr = tbl[i].data;
            #1 check($sformatf("vec%0d cdata_rd", i), 32'(bus.cdata_rd), 32'(tbl[i].exp_rd));
            step();
            bus.cwr = 1'b0; bus.crd = 1'b0;
            check($sformatf("vec%0d wr_cnt", i), 32'(bus.wr_cnt), 32'(tbl[i].exp_cnt));
            check($sformatf("vec%0d err_sel", i), 32'(bus.err_sel), 32'(tbl[i].exp_err));
        end

        bus.busy = 1'b0;
        step();
        wait_done(13000, n_cyc);
        check("scan1 done", 32'(bus.done), 32'd1);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart err_sel clr", 32'(bus.err_sel), 32'd0);
        check("restart wr_cnt clr", 32'(bus.wr_cnt), 32'd0);
        check("restart done clr", 32'(bus.done), 32'd0);
        check("restart ready", 32'(bus.ready), 32'd1);

        bus.busy = 1'b1;
        step();
        fill_ones();
        check("fill wr_cnt", 32'(bus.wr_cnt), 32'd12288);
        bus.busy = 1'b0;
        step();
        wait_done(13000, n_cyc);
        check("scan2 length", 32'(n_cyc), 32'd12288);
        check("scan2 checksum", bus.checksum, 32'h00003000);
        check("scan2 wr_cnt", 32'(bus.wr_cnt), 32'd12288);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.busy = 1'b1;
        step();
        bus.busy = 1'b0;
        step();
        repeat (100) step();
        check("mid-scan checksum", bus.checksum, 32'd100);
        #2 reset = 1'b0;
        #1 check("async rst checksum", bus.checksum, 32'd0);
        check("async rst done", 32'(bus.done), 32'd0);
        check("async rst ready", 32'(bus.ready), 32'd0);
        #1 reset = 1'b1;
        step();

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("rerun ready", 32'(bus.ready), 32'd1);
        bus.busy = 1'b1;
        step();
        bus.busy = 1'b0;
        step();
        wait_done(13000, n_cyc);
        check("rerun length", 32'(n_cyc), 32'd12288);
        check("rerun checksum", bus.checksum, 32'h00003000);
        check("rerun wr_cnt", 32'(bus.wr_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv_mem_host.md
# conv_mem_host

Host-side responder for the CONV accelerator. It holds the input image memory and the five csel-selected layer memories, and answers CONV's `iaddr`/`idata`, `cwr` and `crd` accesses. It also drives the `ready`/`busy` start handshake. After CONV drops `busy`, it scans every layer memory and reports a checksum and a write count for self-checking at system level.

## Interface
Parameters:
- `DW`, 20: data width of all memories.
- `IMG_AW`, 12: image address width (4096 words).
- `L0_AW`, 12: layer-0 bank address width (csel 1, 2).
- `L1_AW`, 10: layer-1 bank address width (csel 3, 4).
- `L2_AW`, 11: layer-2 bank address width (csel 5).

Ports (one clock `clk`; reset is asynchronous and active-low, port named `reset`, asserted at 0):
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: async active-low reset.
- `start` in 1: host request to launch one CONV run.
- `img_we` in 1: image load strobe.
- `img_waddr` in IMG_AW: image load address.
- `img_wdata` in DW: image load data.
- `ready` out 1: start request to CONV.
- `busy` in 1: CONV busy.
- `iaddr` in 12: CONV image read address.
- `idata` out DW: image word at `iaddr`.
- `cwr` in 1: layer write strobe.
- `caddr_wr` in 12: layer write address.
- `cdata_wr` in DW: layer write data.
- `crd` in 1: layer read strobe.
- `caddr_rd` in 12: layer read address.
- `cdata_rd` out DW: layer read data.
- `csel` in 3: bank select.
- `done` out 1: scan complete; held high until the next accepted `start`.
- `checksum` out 32: scan result.
- `wr_cnt` out 16: accepted layer writes this run.
- `err_sel` out 1: sticky flag for an access with an illegal `csel`.

## Operation
- FSM states: IDLE, ARM, RUN, SCAN, DONE.
  - IDLE→ARM on `start`.
  - ARM→RUN when `busy`=1.
  - RUN→SCAN when `busy`=0.
  - SCAN→DONE after the last bank-5 word.
  - DONE→ARM on `start`.
- `start` is ignored in ARM, RUN and SCAN.
- `ready` = 1 exactly while in ARM.
- Image writes are honoured only in IDLE and DONE; they are dropped silently elsewhere.
- `idata` = image[`iaddr`], combinational, in every state.
- Bank decode:
  - csel=1: L0K0, addr[L0_AW-1:0].
  - csel=2: L0K1, addr[L0_AW-1:0].
  - csel=3: L1K0, addr[L1_AW-1:0].
  - csel=4: L1K1, addr[L1_AW-1:0].
  - csel=5: L2, addr[L2_AW-1:0].
  - Upper address bits are ignored.
- A write occurs at the rising edge with `cwr`=1 and legal `csel`, in any state except SCAN.
  - Each such write increments `wr_cnt`, which saturates at 0xFFFF.
- `cdata_rd` = bank[csel][caddr_rd] when `crd`=1 and `csel` is legal; otherwise 0. It is combinational.
- `err_sel` is set on `cwr` or `crd` with csel ∈ {0, 6, 7}.
  - That write is dropped and the read returns 0.
  - It is cleared only by reset or an accepted `start`.
- An accepted `start` clears `done`, `checksum`, `wr_cnt` and `err_sel`.
- Memories are never cleared. A location that was never written holds an undefined value, and so does any checksum that includes it.
- SCAN reads one word per cycle through an internal port, in order: L0K0 0..4095, L0K1, L1K0 0..1023, L1K1, L2 0..2047.
  - `checksum` += zero-extended word, mod 2^32.
  - `cwr` and `crd` are ignored during SCAN.

## Timing
- Reset values: state IDLE, `ready`=0, `done`=0, `checksum`=0, `wr_cnt`=0, `err_sel`=0. Combinational `cdata_rd` is 0 because `crd` is expected low.
- Reset may be asserted mid-operation. The FSM returns to IDLE immediately; memory contents are retained but undefined if the reset edge coincides with a write.
- `start` sampled at edge N gives `ready`=1 from N+1. `ready` falls on the edge after `busy` is first sampled 1.
- `busy` sampled 0 in RUN at edge M puts the block in SCAN from M+1.
- Total SCAN length is 2·2^L0_AW + 2·2^L1_AW + 2^L2_AW cycles (12288 at defaults). `done` and the final `checksum` appear on the edge after the last word is accumulated.
- `busy`=0 while in ARM (CONV not yet started): the block stays in ARM.
- Simultaneous `cwr` and `crd` to the same bank and address: `cdata_rd` shows the old data that cycle; the new data is visible from the next cycle.
- `start` and `img_we` in the same cycle in IDLE: the image write is taken and the FSM enters ARM.

## Test plan
- Reset, then `start` pulse: `ready` high from the next edge. Hold `busy`=0 for 10 cycles: `ready` stays 1. Raise `busy`: `ready` drops one edge later.
- Load image[0x041]=0x12345 in IDLE, then drive `iaddr`=0x041: `idata`=0x12345. An `img_we` issued in RUN leaves the image unchanged.
- In RUN, write csel=3 addr 0xC05 data 0x0ABCD, then `crd` with csel=3 addr 0x005: `cdata_rd`=0x0ABCD, `wr_cnt`=1. With `crd`=0: `cdata_rd`=0.
- `cwr` with csel=6: `err_sel`=1, `wr_cnt` unchanged, no bank modified. The next accepted `start` clears `err_sel`.
- Fill every bank with 1 during RUN, then drop `busy`: `done` rises exactly 12288 cycles after entering SCAN, `checksum`=0x00003000, `wr_cnt`=12288.
- Assert reset in the middle of SCAN: `done`=0 and `checksum`=0 immediately. A new `start` and run completes normally.
